// File: rtl/fc_stream_layer_if.sv
// Bus bundle for fc_stream_layer: config writes, sample stream in, result vector out.
// master = the side driving samples/config, slave = the layer itself.
interface fc_stream_layer_if #(
  parameter int unsigned NUM_NEURONS  = 8,
  parameter int unsigned INPUT_SIZE   = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned ACC_WIDTH    = 32
);
  localparam int unsigned AW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

  logic                                cfg_w_we;
  logic [AW-1:0]                       cfg_w_addr;
  logic [NUM_NEURONS*WEIGHT_WIDTH-1:0] cfg_w_data;
  logic                                cfg_b_we;
  logic [NUM_NEURONS*ACC_WIDTH-1:0]    cfg_b_data;
  logic                                cfg_err;
  logic                                in_valid;
  logic                                in_ready;
  logic [DATA_WIDTH-1:0]               in_data;
  logic                                in_last;
  logic                                frame_err;
  logic                                out_valid;
  logic                                out_ready;
  logic [NUM_NEURONS*ACC_WIDTH-1:0]    out_data;
  logic                                busy;

  modport master (
    output cfg_w_we, cfg_w_addr, cfg_w_data, cfg_b_we, cfg_b_data,
    output in_valid, in_data, in_last, out_ready,
    input  cfg_err, in_ready, frame_err, out_valid, out_data, busy
  );

  modport slave (
    input  cfg_w_we, cfg_w_addr, cfg_w_data, cfg_b_we, cfg_b_data,
    input  in_valid, in_data, in_last, out_ready,
    output cfg_err, in_ready, frame_err, out_valid, out_data, busy
  );
endinterface

// File: rtl/fc_stream_layer.sv
// Streaming fully-connected layer: per-sample parallel MACs against a programmable weight row,
// bias add at frame end, backpressured result vector. Optional ReLU via FC_STREAM_LAYER_RELU_EN.
module fc_stream_layer #(
  parameter int unsigned NUM_NEURONS  = 8,
  parameter int unsigned INPUT_SIZE   = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned ACC_WIDTH    = 32
) (
  input logic              clk,
  input logic              rst,
  fc_stream_layer_if.slave bus
);
  localparam int unsigned AW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int unsigned PW = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int unsigned RW = NUM_NEURONS * WEIGHT_WIDTH;
  localparam int unsigned BW = NUM_NEURONS * ACC_WIDTH;
  localparam logic [AW-1:0]  LAST_IDX  = AW'(INPUT_SIZE - 1);
  localparam logic [AW:0]    ADDR_SPAN = (AW + 1)'(INPUT_SIZE);

  if (ACC_WIDTH < DATA_WIDTH + WEIGHT_WIDTH) begin : g_acc_width_check
    $error("fc_stream_layer: ACC_WIDTH must be >= DATA_WIDTH + WEIGHT_WIDTH");
  end
  if (INPUT_SIZE < 2) begin : g_input_size_check
    $error("fc_stream_layer: INPUT_SIZE must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_BIAS  = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [AW-1:0]               cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q    [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0] acc_d    [NUM_NEURONS];
  logic signed [PW-1:0]        prod_c   [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0] biased_c [NUM_NEURONS];
  logic [BW-1:0]               out_data_q, out_data_d;
  logic                        out_valid_q, in_ready_q, busy_q;
  logic                        frame_err_q, frame_err_d, cfg_err_q, cfg_err_d;

  // Weight rows and bias are plain registers, deliberately outside reset.
  logic [RW-1:0]               w_mem [INPUT_SIZE];
  logic [BW-1:0]               b_mem;
  logic [RW-1:0]               w_row_c;

  logic in_hs_c, out_hs_c, idle_c, w_addr_ok_c, w_wr_c, b_wr_c;

  assign in_hs_c     = bus.in_valid && in_ready_q && (state_q == ST_ACCUM);
  assign out_hs_c    = out_valid_q && bus.out_ready;
  assign idle_c      = (state_q == ST_ACCUM) && (cnt_q == '0);
  assign w_addr_ok_c = ({1'b0, bus.cfg_w_addr} < ADDR_SPAN);
  assign w_wr_c      = !rst && bus.cfg_w_we && idle_c && w_addr_ok_c;
  assign b_wr_c      = !rst && bus.cfg_b_we && idle_c;
  assign cfg_err_d   = (bus.cfg_w_we && !(idle_c && w_addr_ok_c)) || (bus.cfg_b_we && !idle_c);
  assign w_row_c     = w_mem[cnt_q];

  // Full-precision signed products, one per lane, against the row selected by cnt.
  always_comb begin
    for (int n = 0; n < int'(NUM_NEURONS); n++) begin
      prod_c[n] = PW'($signed(bus.in_data)) * PW'($signed(w_row_c[n*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
    end
  end

  // Wrapping bias add, optionally clamped at zero per lane.
  always_comb begin
    for (int n = 0; n < int'(NUM_NEURONS); n++) begin
      biased_c[n] = acc_q[n] + $signed(b_mem[n*ACC_WIDTH +: ACC_WIDTH]);
`ifdef FC_STREAM_LAYER_RELU_EN
      if (biased_c[n][ACC_WIDTH-1]) biased_c[n] = '0;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    frame_err_d = 1'b0;
    unique case (state_q)
      ST_ACCUM: begin
        if (in_hs_c) begin
          if (cnt_q == LAST_IDX) begin
            for (int n = 0; n < int'(NUM_NEURONS); n++) begin
              acc_d[n] = acc_q[n] + ACC_WIDTH'(prod_c[n]);
            end
            cnt_d       = '0;
            state_d     = ST_BIAS;
            frame_err_d = !bus.in_last;
          end else if (bus.in_last) begin
            // Early end of frame: drop the sample and the partial sums.
            for (int n = 0; n < int'(NUM_NEURONS); n++) begin
              acc_d[n] = '0;
            end
            cnt_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            for (int n = 0; n < int'(NUM_NEURONS); n++) begin
              acc_d[n] = acc_q[n] + ACC_WIDTH'(prod_c[n]);
            end
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      ST_BIAS: begin
        for (int n = 0; n < int'(NUM_NEURONS); n++) begin
          out_data_d[n*ACC_WIDTH +: ACC_WIDTH] = biased_c[n];
        end
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_hs_c) begin
          for (int n = 0; n < int'(NUM_NEURONS); n++) begin
            acc_d[n] = '0;
          end
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      cnt_q       <= '0;
      for (int n = 0; n < int'(NUM_NEURONS); n++) begin
        acc_q[n] <= '0;
      end
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= (state_d == ST_OUT);
      in_ready_q  <= (state_d == ST_ACCUM);
      busy_q      <= (cnt_d != '0) || (state_d != ST_ACCUM);
      frame_err_q <= frame_err_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Config storage; a same-cycle sample read still sees the old contents.
  always_ff @(posedge clk) begin
    if (w_wr_c) w_mem[bus.cfg_w_addr] <= bus.cfg_w_data;
    if (b_wr_c) b_mem <= bus.cfg_b_data;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.cfg_err   = cfg_err_q;
endmodule

// File: doc/fc_stream_layer.md
Name: fc_stream_layer

Overview:
- Parametrised successor to the fixed-ROM FC input layer. It is a fully-connected layer with a streaming input and programmable weight/bias storage.
- Consumes one input sample per valid/ready handshake and performs NUM_NEURONS parallel MACs against a runtime-loaded weight row.
- Adds bias after the last sample, then presents the result vector on a valid/ready output with backpressure.
- Sits between the upstream sample streamer and downstream activation/next-layer blocks.

Parameters:
- NUM_NEURONS, 8, number of output neurons (parallel MAC lanes).
- INPUT_SIZE, 16, samples per frame; must be >= 2.
- DATA_WIDTH, 8, signed input sample width.
- WEIGHT_WIDTH, 8, signed weight width.
- ACC_WIDTH, 32, signed accumulator, bias and output width; must be >= DATA_WIDTH+WEIGHT_WIDTH (elaboration $error otherwise).
- AW, $clog2(INPUT_SIZE), weight address width (localparam).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- cfg_w_we  input  1  weight row write strobe.
- cfg_w_addr  input  AW  weight row address (sample index).
- cfg_w_data  input  NUM_NEURONS*WEIGHT_WIDTH  packed row; lane n at [n*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- cfg_b_we  input  1  bias vector write strobe.
- cfg_b_data  input  NUM_NEURONS*ACC_WIDTH  packed bias vector; lane n at [n*ACC_WIDTH +: ACC_WIDTH].
- cfg_err  output  1  one-cycle pulse when a cfg write is dropped.
- in_valid  input  1  sample valid.
- in_ready  output  1  sample ready.
- in_data  input  DATA_WIDTH  signed sample.
- in_last  input  1  marks the final sample of a frame.
- frame_err  output  1  one-cycle pulse on in_last mismatch.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream ready.
- out_data  output  NUM_NEURONS*ACC_WIDTH  packed signed results; lane n at [n*ACC_WIDTH +: ACC_WIDTH].
- busy  output  1  high when a frame is in progress (cnt != 0 or state != ACCUM).

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and fixed.
- States:
  - ACCUM: in_ready=1; holds sample counter cnt (0..INPUT_SIZE-1).
  - BIAS: one cycle.
  - OUT: out_valid=1 until the handshake completes.
- Reset:
  - state=ACCUM, cnt=0, accumulators=0.
  - out_valid=0, out_data=0, cfg_err=0, frame_err=0, busy=0.
  - in_ready=0 while rst is high, 1 the cycle after release.
  - Weight/bias storage is NOT cleared by reset.
- Input handshake is in_valid&&in_ready. On a handshake in ACCUM:
  - acc[n] += sext(in_data*W[cnt][n]) for every lane n; cnt++.
  - Products are full-precision signed, sign-extended to ACC_WIDTH.
  - Accumulation wraps two's-complement at ACC_WIDTH (no saturation).
- in_last rules:
  - Handshake at cnt==INPUT_SIZE-1: cnt->0, go to BIAS. If in_last==0, pulse frame_err; the frame still completes.
  - in_last==1 at cnt<INPUT_SIZE-1: abort. The sample is discarded, accumulators are cleared, cnt->0, frame_err pulses, no output is produced, state stays ACCUM.
- BIAS: acc[n] += B[n] (wrapping), registered into out_data; go to OUT.
- OUT: out_valid=1, out_data stable, in_ready=0.
  - On out_valid&&out_ready: clear accumulators, go to ACCUM.
  - The next frame's first sample is accepted the cycle after the output handshake.
- Latency: final sample handshake at cycle T -> out_valid=1 at T+2. With out_ready held high, throughput is one frame per INPUT_SIZE+2 cycles.
- Config writes:
  - Accepted only when idle (state ACCUM, cnt==0); they take effect the next cycle.
  - A sample handshaken in the same cycle as a write uses the pre-write contents (read-before-write).
  - Writes arriving while busy are dropped, and cfg_err pulses for one cycle (a single pulse even if both strobes are high).
  - cfg_w_addr >= INPUT_SIZE: write dropped, cfg_err pulses.
- Reset asserted mid-frame or during OUT: the frame is lost and the block returns to reset values next cycle.
- Weight read is combinational from register storage indexed by cnt, so there is no read latency.

Optional Feature:
- Macro FC_STREAM_LAYER_RELU_EN.
- Defined: in BIAS, any lane whose biased sum is negative is stored as 0 in out_data (ReLU fused). Applied per lane after the wrapping bias add.
- Undefined: raw signed biased sums are output. No other behaviour differs; latency is identical.

Test Plan:
- Basic frame: NUM_NEURONS=4, INPUT_SIZE=4; all rows W[*][n]=n+1, B[n]=10*n; inputs 1,2,3,4 with in_last on the 4th -> out_data lanes 10,30,50,70; out_valid exactly 2 cycles after the last handshake.
- Backpressure: same frame with out_ready=0 for 5 cycles -> out_valid stays 1, out_data stable, in_ready=0 throughout; after the handshake, in_ready=1 next cycle and a second identical frame yields 10,30,50,70.
- Early in_last: in_last on the 2nd sample -> frame_err pulses once, no out_valid; the following correct frame yields 10,30,50,70 (accumulators cleared).
- Missing in_last on the 4th sample -> frame_err pulse, and out_data is still 10,30,50,70.
- Config guard: cfg_w_we while cnt==2 -> cfg_err one-cycle pulse, weights unchanged (frame result unchanged). A write at idle in the same cycle as the first sample handshake -> that sample uses the old row.
- Sign/wrap/ReLU: ACC_WIDTH=16, INPUT_SIZE=2, W=-128, B=0, inputs -128,-128 -> lane = 32768 wrapped = -32768 without the macro; 0 with FC_STREAM_LAYER_RELU_EN.
